// File: rtl/secded_batch_decoder.sv
// Hamming SECDED batch decoder: reads COUNT codewords from byte memory, corrects
// single errors, flags double errors and writes data plus a 2-bit status tag back.
module secded_batch_decoder #(
  parameter int P        = 4,
  parameter int COUNT    = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          done,
  output logic [7:0]    single_cnt,
  output logic [7:0]    double_cnt
);

  localparam int CW    = 1 << P;
  localparam int DW    = CW - P - 1;
  localparam int BYTES = CW / 8;

  // state | meaning
  // RD    | present read address of byte b, capture byte b-1
  // RDW   | capture last byte of the codeword
  // DEC   | classify, correct, register result, bump counters
  // WR    | write result bytes LSB first
  // DONE  | run complete, idle until reset
  localparam logic [2:0] S_RD   = 3'd0;
  localparam logic [2:0] S_RDW  = 3'd1;
  localparam logic [2:0] S_DEC  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  if (P < 3 || P > 6) begin : g_bad_p
    $error("secded_batch_decoder: P must be in 3..6");
  end
  if (COUNT < 1 || COUNT > 255) begin : g_bad_count
    $error("secded_batch_decoder: COUNT must be in 1..255");
  end
  if (SRC_BASE < DST_BASE + BYTES * COUNT && DST_BASE < SRC_BASE + BYTES * COUNT) begin : g_overlap
    $error("secded_batch_decoder: source and destination regions overlap");
  end

  logic [2:0]    state_q, state_d;
  logic [2:0]    byte_q, byte_d;
  logic [7:0]    word_q, word_d;
  logic [CW-1:0] cw_q, cw_d;
  logic [CW-1:0] res_q, res_d;
  logic [7:0]    single_q, single_d;
  logic [7:0]    double_q, double_d;

  logic [P-1:0]  syn;
  logic          par;
  logic [CW-1:0] corr;
  logic [DW-1:0] data;
  logic [1:0]    status;

  always_comb begin
    int k;
    syn = '0;
    for (int i = 1; i < CW; i++) begin
      if (cw_q[i]) syn ^= i[P-1:0];
    end
    par  = ^cw_q;
    corr = cw_q;
    if (par) corr[syn] = ~cw_q[syn];
    // data bits occupy the non-power-of-two positions in ascending order
    data = '0;
    k    = 0;
    for (int i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        data[k] = corr[i];
        k++;
      end
    end
    if (par)              status = 2'b01;
    else if (syn != '0)   status = 2'b10;
    else                  status = 2'b00;
    res_d = '0;
    res_d[DW-1:0]     = data;
    res_d[CW-1:CW-2]  = status;
  end

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    word_d   = word_q;
    cw_d     = cw_q;
    single_d = single_q;
    double_d = double_q;
    case (state_q)
      S_RD: begin
        if (byte_q != 3'd0) cw_d[8*(int'(byte_q)-1) +: 8] = mem_rdata;
        if (byte_q == 3'(BYTES-1)) begin
          state_d = S_RDW;
          byte_d  = 3'd0;
        end else begin
          byte_d = byte_q + 3'd1;
        end
      end
      S_RDW: begin
        cw_d[8*(BYTES-1) +: 8] = mem_rdata;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (status == 2'b01 && single_q != 8'hFF) single_d = single_q + 8'd1;
        if (status == 2'b10 && double_q != 8'hFF) double_d = double_q + 8'd1;
        state_d = S_WR;
      end
      S_WR: begin
        if (byte_q == 3'(BYTES-1)) begin
          byte_d  = 3'd0;
          word_d  = word_q + 8'd1;
          state_d = (word_q == 8'(COUNT-1)) ? S_DONE : S_RD;
        end else begin
          byte_d = byte_q + 3'd1;
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RD;
      byte_q   <= 3'd0;
      word_q   <= 8'd0;
      cw_q     <= '0;
      res_q    <= '0;
      single_q <= 8'd0;
      double_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      word_q   <= word_d;
      cw_q     <= cw_d;
      single_q <= single_d;
      double_q <= double_d;
      if (state_q == S_DEC) res_q <= res_d;
    end
  end

  always_comb begin
    mem_wr_en = (state_q == S_WR);
    mem_wdata = mem_wr_en ? res_q[8*int'(byte_q) +: 8] : 8'h00;
    if (state_q == S_WR)
      mem_addr = AW'(DST_BASE + BYTES * int'(word_q) + int'(byte_q));
    else if (state_q == S_DONE)
      mem_addr = AW'(SRC_BASE);
    else
      mem_addr = AW'(SRC_BASE + BYTES * int'(word_q) + int'(byte_q));
  end

  assign done       = (state_q == S_DONE);
  assign single_cnt = single_q;
  assign double_cnt = double_q;

endmodule

// File: doc/secded_batch_decoder.md
# secded_batch_decoder

Parametrised hardware Hamming SECDED batch decoder. After reset it reads `COUNT` codewords from byte-wide data memory, checks and corrects each, and writes the data word with a 2-bit status tag back to memory. It then raises `done` and holds it. It replaces the software decode loop for program 2 and generalises it to any Hamming code of length 2^P, with running error counters.

## Interface
- `P`, 4, parity-position bit count. Codeword width CW = 2^P (P in 3..6). Data width DW = 2^P − P − 1 (P=4: CW=16, DW=11).
- `COUNT`, 15, number of codewords per run (1..255).
- `SRC_BASE`, 30, byte address of codeword 0.
- `DST_BASE`, 0, byte address of result word 0. The two regions must not overlap; elaboration asserts this.
- `AW`, 8, memory address width.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; also acts as the run request. The run starts on the first cycle with `reset` low.
- `mem_addr`  out  AW  byte address (reads and writes).
- `mem_wr_en`  out  1  write strobe for the current cycle.
- `mem_wdata`  out  8  write byte.
- `mem_rdata`  in  8  read byte; valid the cycle after `mem_addr` is presented (synchronous read).
- `done`  out  1  run complete; held high until next reset.
- `single_cnt`  out  8  codewords with a corrected single error; saturates at 255.
- `double_cnt`  out  8  codewords flagged as double errors; saturates at 255.

## Operation
- Byte layout: BYTES = CW/8. Word i lives at `SRC_BASE + BYTES*i` (LSB byte first); its result goes to `DST_BASE + BYTES*i`, also little-endian.
- Codeword bit layout:
  - Bit 0 is overall parity p0.
  - Bits 2^k (k = 0..P−1) are Hamming parity bits.
  - Remaining positions carry data, ascending: lowest free position holds data bit 1.
  - P=4: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
- Syndrome s (P bits) = XOR of the indices of all set bits at positions 1..CW−1. Overall parity g = XOR of all CW bits.
- Classification:
  - s=0, g=0: clean. Status 00, data as received.
  - g=1: single error at position s (s=0 means p0 flipped). Flip that bit, extract data. Status 01. `single_cnt`++.
  - s≠0, g=0: double error. Status 10. Data field carries the uncorrected extracted data. `double_cnt`++.
- Result word (CW bits): [CW−1:CW−2] = status, [DW−1:0] = data, all other bits 0. P=4, single error: {2'b01, 3'b000, d[11:1]}.
- FSM states: RD, RDW, DEC, WR, DONE.
  - RD: issue BYTES read addresses, byte index b = 0..BYTES−1. Capture byte b−1 each cycle after the first.
  - RDW: capture last byte.
  - DEC: compute s, g and the result; update counters; register the result.
  - WR: BYTES write cycles, LSB first, `mem_wr_en`=1.
  - After the last WR byte: word index +1. If index = COUNT, go to DONE; otherwise go to RD.
  - DONE: `mem_wr_en`=0, `done`=1, no further memory traffic, hold until reset.
- `mem_wr_en` is high only in WR. Reads are never issued in WR.

## Timing
- Reset values: `done`=0, `mem_wr_en`=0, `mem_addr`=SRC_BASE, `mem_wdata`=0, `single_cnt`=0, `double_cnt`=0. FSM is in RD with word 0, byte 0.
- Per word: 2·BYTES + 2 cycles (P=4: 6 cycles).
- `done` rises on the edge that ends cycle COUNT·(2·BYTES+2) counted from the first cycle with `reset` low (P=4, COUNT=15: 90 cycles).
- Counters update on the DEC edge. They are stable and final when `done` rises.
- Reset asserted mid-run, including during WR: next edge restores all reset values and aborts the partial write (a half-written word may remain). Deassertion starts a fresh run from word 0 with counters cleared.
- Reset held high: outputs stay at reset values and no memory writes occur.
- Counter saturation: at 255, further events do not wrap.

## Test plan
- Clean codewords, P=4, COUNT=15. Random d, no flips. Expected: every result = {5'b00000, d}; both counters 0; `done` at cycle 90.
- Single flip at each position 0..15 of data 11'h5A3. Expected: {5'b01000, 11'h5A3}; `single_cnt`=16 after a COUNT=16 run.
- Double flips at positions (3,9) and (0,15) of 11'h7FF. Expected: bit15=1, bit14=0, data field = raw extracted bits; `double_cnt`=2.
- Reset pulsed at cycle 40 of a run. Expected: `done` low, counters 0; the rerun completes 90 cycles after deassert with correct outputs.
- P=5 (CW=32, DW=26, BYTES=4), COUNT=3: single error at bit 21 of 26'h2ABCDEF. Expected: 4-byte result {2'b01, 4'b0, 26'h2ABCDEF}; 10 cycles per word.
- Memory monitor across all runs. Expected: no writes outside the DST range; `mem_wr_en`=0 whenever `done`=1.
